bin2bcd_serial: RTL and testbench

BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

---
 rtl/bin2bcd_serial_pkg.sv | 18 +
 rtl/bin2bcd_serial_digit_adjust.sv | 12 +
 rtl/bin2bcd_serial.sv | 115 +++++++++++
 tb/tb_bin2bcd_serial.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_serial_pkg.sv
// Shared types for the serial binary-to-BCD converter: the FSM state encoding,
// the BCD digit type and the minimum digit count for a given binary width.
package bin2bcd_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // ceil(bits * log10(2)), using log10(2) ~= 0.30103 in integer arithmetic
  function automatic int min_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_serial_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
import bin2bcd_serial_pkg::*;

module bcd_digit_adjust (
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one input bit per clock, the result is presented
// together with a one-cycle done pulse and a leading-zero blanking mask.
import bin2bcd_serial_pkg::*;

module bin2bcd_serial #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank
);

  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int TOTAL_W = 4 * DIGITS + BIN_W;

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $error("bin2bcd_serial: DIGITS=%0d cannot hold a %0d-bit value", DIGITS, BIN_W);
  end

  state_t               state;
  state_t               next_state;
  logic [BIN_W-1:0]     shift_reg;
  logic [4*DIGITS-1:0]  scratch;
  logic [CNT_W-1:0]     count;

  logic [4*DIGITS-1:0]  adjusted;
  logic [TOTAL_W-1:0]   shifted;
  logic [4*DIGITS-1:0]  scratch_next;
  logic [BIN_W-1:0]     shift_next;
  logic [DIGITS-1:0]    blank_next;
  logic                 last_shift;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (scratch[4*k +: 4]),
      .digit_out (adjusted[4*k +: 4])
    );
  end

  // Digit carries fall out of shifting the concatenation; the top digit's MSB is dropped
  assign shifted      = {adjusted, shift_reg} << 1;
  assign scratch_next = shifted[TOTAL_W-1 -: 4*DIGITS];
  assign shift_next   = shifted[BIN_W-1:0];
  assign last_shift   = (state == SHIFT) && (count == CNT_W'(1));
  assign o_busy       = (state != IDLE);

  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    blank_next = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run      = zero_run && (scratch_next[4*k +: 4] == 4'd0);
      blank_next[k] = zero_run;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are loaded on the final shift so they change exactly when o_done rises
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      o_done    <= 1'b0;
      o_bcd     <= '0;
      o_blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shift_reg <= i_bin;
            scratch   <= '0;
            count     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          count     <= count - CNT_W'(1);
          if (last_shift) begin
            o_bcd   <= scratch_next;
            o_blank <= blank_next;
            o_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: directed corner cases plus randomized
// back-to-back conversions compared against a decimal-arithmetic model.
module tb_bin2bcd_serial;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic [19:0] o_bcd;
  logic [4:0]  o_blank;

  int checks = 0;
  int errors = 0;

  bin2bcd_serial #(.BIN_W(16), .DIGITS(5)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_bcd   (o_bcd),
    .o_blank (o_blank)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [19:0] model_bcd(input int value);
    logic [19:0] r;
    int v;
    v = value;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input int value);
    logic [4:0] r;
    int ndig;
    int v;
    ndig = 1;
    v = value / 10;
    while (v > 0) begin
      ndig++;
      v = v / 10;
    end
    r = '0;
    for (int k = 1; k < 5; k++) r[k] = (k >= ndig);
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic start, input logic [15:0] bin);
    i_rst   = rst;
    i_start = start;
    i_bin   = bin;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Start a conversion, then verify busy, latency to done and the final result
  task automatic runConversion(input string tag, input int value);
    int cyc;
    logic busy_ok;
    applyStimulus(1'b0, 1'b1, 16'(value));
    tick();
    applyStimulus(1'b0, 1'b0, 16'($urandom));
    cyc = 1;
    busy_ok = 1'b1;
    while (!o_done && cyc < 40) begin
      if (!o_busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, 17);
    checkOutput({tag, "_busy_during"}, {31'd0, busy_ok}, 1);
    checkOutput({tag, "_busy_at_done"}, {31'd0, o_busy}, 1);
    checkOutput({tag, "_bcd"}, {12'd0, o_bcd}, {12'd0, model_bcd(value)});
    checkOutput({tag, "_blank"}, {27'd0, o_blank}, {27'd0, model_blank(value)});
    tick();
    checkOutput({tag, "_done_pulse"}, {31'd0, o_done}, 0);
    checkOutput({tag, "_idle"}, {31'd0, o_busy}, 0);
    checkOutput({tag, "_hold"}, {12'd0, o_bcd}, {12'd0, model_bcd(value)});
  endtask

  initial begin
    int pulses;
    int val;
    logic [19:0] seen_bcd;

    $display("[TB] starting bin2bcd_serial bench");
    applyStimulus(1'b1, 1'b0, 16'd0);
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, o_busy}, 0);
    checkOutput("reset_done", {31'd0, o_done}, 0);
    checkOutput("reset_bcd", {12'd0, o_bcd}, 0);
    checkOutput("reset_blank", {27'd0, o_blank}, 32'h1E);
    applyStimulus(1'b0, 1'b0, 16'd0);
    tick();

    runConversion("zero", 0);
    checkOutput("zero_blank_const", {27'd0, o_blank}, 32'h1E);
    runConversion("max", 65535);
    checkOutput("max_bcd_const", {12'd0, o_bcd}, 32'h65535);
    runConversion("n1234", 1234);
    checkOutput("n1234_blank_const", {27'd0, o_blank}, 32'h10);
    runConversion("n9", 9);
    runConversion("n10", 10);
    runConversion("n99999cap", 60000);

    // A start request in the middle of a conversion must be dropped, not queued
    applyStimulus(1'b0, 1'b1, 16'd4321);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b1, 16'd7777);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0);
    pulses = 0;
    seen_bcd = '0;
    for (int i = 0; i < 45; i++) begin
      if (o_done) begin
        pulses++;
        seen_bcd = o_bcd;
      end
      tick();
    end
    checkOutput("ignore_pulses", pulses, 1);
    checkOutput("ignore_bcd", {12'd0, seen_bcd}, 32'h04321);

    // Reset mid-conversion aborts with no done pulse
    applyStimulus(1'b0, 1'b1, 16'd500);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0);
    repeat (7) tick();
    applyStimulus(1'b1, 1'b0, 16'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkOutput("abort_busy", {31'd0, o_busy}, 0);
    checkOutput("abort_bcd", {12'd0, o_bcd}, 0);
    checkOutput("abort_blank", {27'd0, o_blank}, 32'h1E);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (o_done) pulses++;
      tick();
    end
    checkOutput("abort_no_done", pulses, 0);
    runConversion("n500", 500);
    checkOutput("n500_blank_const", {27'd0, o_blank}, 32'h18);

    // Start coinciding with reset is ignored
    applyStimulus(1'b1, 1'b1, 16'd321);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkOutput("rst_start_busy", {31'd0, o_busy}, 0);
    tick();
    checkOutput("rst_start_busy2", {31'd0, o_busy}, 0);

    // Back-to-back with start held high: accepted every 18 cycles
    for (int c = 0; c < 6; c++) begin
      val = (c == 0) ? 65535 : int'($urandom_range(0, 65535));
      applyStimulus(1'b0, 1'b1, 16'(val));
      tick();
      for (int j = 1; j <= 17; j++) begin
        applyStimulus(1'b0, 1'b1, 16'($urandom));
        tick();
        checkOutput($sformatf("b2b%0d_done_c%0d", c, j), {31'd0, o_done}, {31'd0, (j == 16)});
        if (j == 16) begin
          checkOutput($sformatf("b2b%0d_bcd", c), {12'd0, o_bcd}, {12'd0, model_bcd(val)});
          checkOutput($sformatf("b2b%0d_blank", c), {27'd0, o_blank}, {27'd0, model_blank(val)});
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 16'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
